button_conditioner: RTL

Front-end conditioner for a front-panel push button on the synth board. It synchronises the raw pad signal, debounces it, and emits single-cycle press and release pulses plus a long-press pulse. press_pulse drives the toggle input of the play/pause state machine directly downstream, so one physical press produces exactly one toggle. The other outputs are available for mode and clear functions.

---
 rtl/button_conditioner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, debounce FSM, and single-cycle
// press / release / long-press pulses with a registered debounced level.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic          IDLE_PAD  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t        state, state_n;
    logic          s1, s2;
    logic          pressed;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n;
    logic          long_done, long_done_n;
    logic          press_n, release_n, long_n, level_n;
    logic          hold_tick;

    // Sync flops rest at the released pad level so reset exit looks idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= IDLE_PAD;
            s2 <= IDLE_PAD;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    assign pressed = s2 ^ IDLE_PAD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RELEASED;
            cnt           <= '0;
            hold          <= '0;
            long_done     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            btn_level     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            hold          <= hold_n;
            long_done     <= long_done_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            btn_level     <= level_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_n      = hold;
        long_done_n = long_done;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        hold_tick   = 1'b0;

        case (state)
            RELEASED: begin
                if (pressed) begin
                    state_n = PRESS_CHK;
                    cnt_n   = CW'(1);
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_n     = PRESSED;
                    cnt_n       = '0;
                    press_n     = 1'b1;
                    hold_n      = '0;
                    long_done_n = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_n = RELEASE_CHK;
                    cnt_n   = CW'(1);
                end else begin
                    hold_tick = 1'b1;
                end
            end
            RELEASE_CHK: begin
                // A rejected release bounce resumes the hold count on this same
                // edge, so the long press slips by exactly the bounce length
                if (pressed) begin
                    state_n   = PRESSED;
                    cnt_n     = '0;
                    hold_tick = 1'b1;
                end else if (cnt == CNT_DONE) begin
                    state_n   = RELEASED;
                    cnt_n     = '0;
                    release_n = 1'b1;
                    hold_n    = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = RELEASED;
                cnt_n   = '0;
            end
        endcase

        if (hold_tick) begin
            if (hold == HOLD_FIRE && !long_done) begin
                long_n      = 1'b1;
                long_done_n = 1'b1;
            end
            if (hold != HOLD_MAX) begin
                hold_n = hold + HW'(1);
            end
        end

        level_n = (state_n == PRESSED) || (state_n == RELEASE_CHK);
    end

endmodule
